// File: rtl/store_pkg.sv
// Shared store-bus types: funct3 encodings, controller states and access-size decode.
package store_pkg;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  // Bytes written by a store; 0 flags an unsupported funct3.
  function automatic logic [2:0] byte_size(input logic [2:0] funct3);
    case (funct3)
      SB:      byte_size = 3'd1;
      SH:      byte_size = 3'd2;
      SW:      byte_size = 3'd4;
      default: byte_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane placement: positions store data and byte enables across two bus words.
module store_lane_align
  import store_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [63:0] wide,
  output logic [7:0]  be,
  output logic        split,
  output logic        illegal
);

  logic [2:0]  size;
  logic [31:0] dmask;
  logic [3:0]  smask;

  always_comb begin
    size  = byte_size(funct3);
    dmask = 32'h0;
    smask = 4'b0000;
    case (size)
      3'd1:    begin dmask = 32'h0000_00ff; smask = 4'b0001; end
      3'd2:    begin dmask = 32'h0000_ffff; smask = 4'b0011; end
      3'd4:    begin dmask = 32'hffff_ffff; smask = 4'b1111; end
      default: begin dmask = 32'h0;         smask = 4'b0000; end
    endcase
    wide    = {32'b0, data & dmask} << {off, 3'b000};
    be      = {4'b0, smask} << off;
    illegal = (size == 3'd0);
    // off+size needs 3 bits: worst case 3+4 = 7
    split   = ({1'b0, off} + size) > 3'd4;
  end

endmodule

// File: rtl/store_bus_ctrl.sv
// Store bus controller: accepts one core store, issues one or two word-aligned bus beats.
module store_bus_ctrl
  import store_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        st_funct3,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              st_done,
  output logic              st_err
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [2:0]        f3_q;
  logic              err_q;

  logic [31:0] a_data;
  logic [2:0]  a_f3;
  logic [1:0]  a_off;
  logic [63:0] a_wide;
  logic [7:0]  a_be;
  logic        a_split, a_illegal;
  logic        accept, reject, ack;

  // In IDLE the aligner sees the incoming store so beat0 can be loaded on the accept edge.
  assign a_data = (state == IDLE) ? st_data   : data_q;
  assign a_f3   = (state == IDLE) ? st_funct3 : f3_q;
  assign a_off  = (state == IDLE) ? st_addr[1:0] : addr_q[1:0];

  store_lane_align u_align (
    .data    (a_data),
    .funct3  (a_f3),
    .off     (a_off),
    .wide    (a_wide),
    .be      (a_be),
    .split   (a_split),
    .illegal (a_illegal)
  );

  assign st_ready = (state == IDLE) && rst_n;
  assign accept   = st_valid && st_ready;
  assign reject   = a_illegal || (a_split && (SPLIT_EN == 1'b0));
  // Acks only count against an outstanding request.
  assign ack      = mem_ack && mem_req;
  assign st_done  = (state == RESP) && !err_q;
  assign st_err   = (state == RESP) && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = reject ? RESP : BEAT0;
      BEAT0:   if (ack)    state_n = a_split ? BEAT1 : RESP;
      BEAT1:   if (ack)    state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      data_q    <= '0;
      f3_q      <= '0;
      err_q     <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q <= st_addr;
          data_q <= st_data;
          f3_q   <= st_funct3;
          err_q  <= reject;
          if (!reject) begin
            mem_req   <= 1'b1;
            mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= a_wide[31:0];
            mem_be    <= a_be[3:0];
          end
        end
        BEAT0: if (ack) begin
          mem_req <= 1'b0;
          // Preload beat1 during the mandatory idle cycle.
          if (a_split) begin
            mem_addr  <= {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(3'd4);
            mem_wdata <= a_wide[63:32];
            mem_be    <= a_be[7:4];
          end
        end
        BEAT1: begin
          if (ack)          mem_req <= 1'b0;
          else if (!mem_req) mem_req <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_bus_ctrl.sv
// Randomized bench for store_bus_ctrl against a byte-by-byte reference model.
module tb_store_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_valid_ns;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_funct3;
  logic        mem_ack, mem_ack_ns;

  logic        rdy0, req0, done0, err0, rdy1, req1, done1, err1;
  logic [31:0] addr0, wd0, addr1, wd1;
  logic [3:0]  be0, be1;

  int n_checks = 0;
  int n_errs   = 0;

  bit          sel;
  logic        c_rdy, c_req, c_done, c_err;
  logic [31:0] c_addr, c_wd;
  logic [3:0]  c_be;

  logic [31:0] exp_addr [0:1];
  logic [31:0] exp_wd   [0:1];
  logic [3:0]  exp_be   [0:1];
  int          exp_nb;
  logic        exp_err;

  always #5 clk = ~clk;

  store_bus_ctrl #(.SPLIT_EN(1'b1), .ADDR_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(rdy0),
    .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .mem_req(req0), .mem_addr(addr0), .mem_wdata(wd0), .mem_be(be0),
    .mem_ack(mem_ack), .st_done(done0), .st_err(err0)
  );

  store_bus_ctrl #(.SPLIT_EN(1'b0), .ADDR_W(32)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid_ns), .st_ready(rdy1),
    .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .mem_req(req1), .mem_addr(addr1), .mem_wdata(wd1), .mem_be(be1),
    .mem_ack(mem_ack_ns), .st_done(done1), .st_err(err1)
  );

  assign c_rdy  = sel ? rdy1  : rdy0;
  assign c_req  = sel ? req1  : req0;
  assign c_done = sel ? done1 : done0;
  assign c_err  = sel ? err1  : err0;
  assign c_addr = sel ? addr1 : addr0;
  assign c_wd   = sel ? wd1   : wd0;
  assign c_be   = sel ? be1   : be0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Place each byte of the store at its own address; bytes past the first word go to beat1.
  task automatic model(input bit split_en, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3);
    int          size;
    logic [31:0] base, ba;
    size = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : (f3 == 3'b010) ? 4 : 0;
    base = a & 32'hffff_fffc;
    exp_addr[0] = base;
    exp_addr[1] = base + 32'd4;
    exp_wd[0] = '0; exp_wd[1] = '0; exp_be[0] = '0; exp_be[1] = '0;
    exp_nb = (size == 0) ? 0 : 1;
    exp_err = (size == 0);
    for (int i = 0; i < size; i++) begin
      int w;
      ba = a + 32'(i);
      w = ((ba & 32'hffff_fffc) != base) ? 1 : 0;
      exp_wd[w][8*ba[1:0] +: 8] = d[8*i +: 8];
      exp_be[w][ba[1:0]] = 1'b1;
      if (w == 1) exp_nb = 2;
    end
    if (!split_en && exp_nb == 2) begin
      exp_nb = 0;
      exp_err = 1'b1;
    end
  endtask

  // Called at a negedge with the selected DUT idle; returns at a negedge with it idle again.
  task automatic run_store(input bit ns, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f3, input int dly);
    sel = ns;
    model(!ns, a, d, f3);
    #1;
    check("ready_idle", c_rdy, 1);
    st_addr = a; st_data = d; st_funct3 = f3;
    if (ns) st_valid_ns = 1'b1; else st_valid = 1'b1;
    @(negedge clk);
    st_valid = 1'b0; st_valid_ns = 1'b0;
    st_addr = $urandom; st_data = $urandom; st_funct3 = 3'($urandom);
    if (exp_err) begin
      check("err_pulse", c_err, 1);
      check("err_nodone", c_done, 0);
      check("err_noreq", c_req, 0);
      @(negedge clk);
      check("err_clear", c_err, 0);
      check("err_ready", c_rdy, 1);
      return;
    end
    for (int b = 0; b < exp_nb; b++) begin
      if (b == 1) @(negedge clk);
      check("req_on", c_req, 1);
      check("ready_busy", c_rdy, 0);
      for (int k = 0; k < dly; k++) @(negedge clk);
      check("req_hold", c_req, 1);
      check("beat_addr", c_addr, exp_addr[b]);
      check("beat_wdata", c_wd, exp_wd[b]);
      check("beat_be", c_be, exp_be[b]);
      if (ns) mem_ack_ns = 1'b1; else mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; mem_ack_ns = 1'b0;
      check("req_drop", c_req, 0);
      check("done_pulse", c_done, (b == exp_nb - 1) ? 1 : 0);
      check("no_err", c_err, 0);
    end
    @(negedge clk);
    check("done_clear", c_done, 0);
    check("ready_back", c_rdy, 1);
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic [2:0]  rf;
    rst_n = 1'b0; st_valid = 1'b0; st_valid_ns = 1'b0;
    st_addr = '0; st_data = '0; st_funct3 = '0; mem_ack = 1'b0; mem_ack_ns = 1'b0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", req0, 0);
    check("rst_ready", rdy0, 0);
    check("rst_addr", addr0, 0);
    check("rst_wdata", wd0, 0);
    check("rst_be", be0, 0);
    check("rst_done_err", {done0, err0}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", rdy0, 1);

    run_store(0, 32'h100, 32'hdeadbeef, 3'b010, 2);
    run_store(0, 32'h203, 32'h0000_00a5, 3'b000, 1);
    run_store(0, 32'h303, 32'h0000_1234, 3'b001, 0);
    run_store(0, 32'h401, 32'h1122_3344, 3'b010, 1);
    run_store(1, 32'h401, 32'h1122_3344, 3'b010, 1);
    run_store(1, 32'h402, 32'h1122_3344, 3'b001, 0);
    run_store(0, 32'h500, 32'h0, 3'b011, 0);
    run_store(0, 32'hffff_fffe, 32'hcafe_f00d, 3'b010, 0);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hffff_fffc | 32'($urandom_range(0, 3));
      rd = $urandom;
      rf = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1; mem_ack_ns = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; mem_ack_ns = 1'b0;
        check("stray_ack_req", {req0, req1}, 0);
        check("stray_ack_done", {done0, done1, err0, err1}, 0);
      end
      run_store(($urandom_range(0, 3) == 0), ra, rd, rf, $urandom_range(0, 3));
    end

    // Reset in the middle of the second beat of a split store.
    sel = 1'b0;
    st_addr = 32'h303; st_data = 32'h1234; st_funct3 = 3'b001; st_valid = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("mid_beat1_req", req0, 1);
    check("mid_beat1_addr", addr0, 32'h304);
    #2 rst_n = 1'b0;
    #1;
    check("async_req_drop", req0, 0);
    check("rst_ready_low", rdy0, 0);
    @(negedge clk);
    check("rst_no_pulse", {done0, err0}, 0);
    check("rst_be_clear", be0, 0);
    rst_n = 1'b1;
    #1;
    check("rel_ready2", rdy0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {req0, done0, err0}, 0);
    end
    run_store(0, 32'h100, 32'hdeadbeef, 3'b010, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_bus_ctrl.md
STORE_BUS_CTRL -- requirements
Module: store_bus_ctrl

Interface
REQ-001 The block SHALL have parameter SPLIT_EN, default 1: 1 = split misaligned stores into two bus beats; 0 = reject them.
REQ-002 The block SHALL have parameter ADDR_W, default 32: byte address width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port st_valid, input, 1: core presents a store.
REQ-007 Port st_ready, output, 1: block accepts a store (st_valid & st_ready).
REQ-008 Port st_addr, input, ADDR_W: byte address.
REQ-009 Port st_data, input, 32: store data, LSB-justified.
REQ-010 Port st_funct3, input, 3: 000 SB, 001 SH, 010 SW.
REQ-011 Port mem_req, output, 1: bus write request.
REQ-012 Port mem_addr, output, ADDR_W: word-aligned address, bits [1:0] = 0.
REQ-013 Port mem_wdata, output, 32: lane-positioned write data.
REQ-014 Port mem_be, output, 4: byte enables.
REQ-015 Port mem_ack, input, 1: bus completes the current beat.
REQ-016 Port st_done, output, 1: one-cycle pulse when the store completes.
REQ-017 Port st_err, output, 1: one-cycle pulse when a store is rejected.

Function
REQ-018 The FSM SHALL have the states IDLE, BEAT0, BEAT1 and RESP.
REQ-019 st_ready SHALL be 1 only in IDLE.
REQ-020 On acceptance, the block SHALL register addr, data and funct3; the off field SHALL be addr[1:0].
REQ-021 Size SHALL be 1, 2 or 4 bytes for funct3 000, 001 or 010.
- Any other funct3 SHALL go to RESP with st_err=1.
- No mem_req SHALL be issued for it.
REQ-022 Lane alignment SHALL work as follows:
- wide = {32'b0, masked data} << (8*off), where masked data keeps size bytes.
- be8 = size mask << off.
- Beat0 uses the low halves; beat1 uses the high halves.
REQ-023 A store SHALL be split when off+size > 4.
- SPLIT_EN=0 with a split store SHALL give st_err with no bus activity.
REQ-024 BEAT0 SHALL drive the following:
- mem_req=1.
- mem_addr = {addr[ADDR_W-1:2],2'b00}.
- Low wdata and be.
REQ-025 mem_req, mem_addr, mem_wdata and mem_be SHALL be registered and SHALL stay stable until mem_ack.
REQ-026 On mem_ack in BEAT0, the FSM SHALL go to BEAT1 if the store is split, else to RESP.
REQ-027 BEAT1 SHALL drive mem_addr = beat0 address + 4, with wrap modulo 2^ADDR_W, plus the high wdata and be.
REQ-028 On mem_ack in BEAT1, the FSM SHALL go to RESP.
REQ-029 mem_req SHALL deassert in the cycle after the accepting ack.
- Back-to-back beats SHALL have exactly one idle cycle between them.
REQ-030 RESP SHALL pulse st_done (success) or st_err for 1 cycle, then return to IDLE.
REQ-031 Latency from acceptance to mem_req SHALL be 1 cycle; a new store SHALL be accepted no earlier than the cycle after RESP.
REQ-032 mem_ack SHALL be ignored outside BEAT0/BEAT1.
REQ-033 mem_ack in the same cycle as mem_req's first assertion SHALL be a valid completion.

Reset
REQ-034 While rst_n=0, the block SHALL hold the following:
- state=IDLE.
- st_ready=1 after reset release, 0 while rst_n is low.
- mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0.
- st_done=0, st_err=0.
REQ-035 Reset mid-transaction SHALL abandon the store with no st_done or st_err.
- mem_req SHALL drop immediately, asynchronously.

Structure
REQ-036 Package store_pkg SHALL hold the following:
- The funct3 constants SB/SH/SW.
- The FSM state enum.
- The byte-size decode function.
REQ-037 Sub-module store_lane_align SHALL be combinational: (data, funct3, off) -> 64-bit wide data, 8-bit be, split flag, illegal flag.

Verification
REQ-038 SW to 0x100, data 0xDEADBEEF, ack after 2 cycles -> one beat: addr 0x100, wdata 0xDEADBEEF, be 1111; st_done 1 cycle after ack.
REQ-039 SB to 0x203, data 0x000000A5 -> one beat: addr 0x200, wdata 0xA5000000, be 1000.
REQ-040 SH to 0x303, data 0x1234, SPLIT_EN=1 -> two beats:
- Beat0: addr 0x300, wdata 0x34000000, be 1000.
- Beat1: addr 0x304, wdata 0x00000012, be 0001.
- st_done once.
REQ-041 SW to 0x401, data 0x11223344 -> be 1110 then 0001; same store with SPLIT_EN=0 -> st_err, mem_req never asserted.
REQ-042 funct3=011 -> st_err, no bus beat; rst_n low during BEAT1 of REQ-040 -> mem_req=0 at once, no st_done, st_ready=1 after release.
